// File: rtl/gerenciador_escritas.sv
// Round-robin write arbiter: grants one expander at a time onto the shared
// memory write ports and returns a one-cycle completion pulse to it.
module gerenciador_escritas #(
    parameter int NUM_WRITE_PORTS = 8,
    parameter int NUM_EA          = 8,
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 8
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic [NUM_EA-1:0]                            lvv_write_en_in,
    input  logic [ADDR_WIDTH*NUM_WRITE_PORTS*NUM_EA-1:0] lvv_write_addr_in,
    input  logic [DATA_WIDTH*NUM_WRITE_PORTS*NUM_EA-1:0] lvv_write_data_in,
    input  logic [NUM_WRITE_PORTS*NUM_EA-1:0]            lvv_write_mask_in,
    output logic [NUM_EA-1:0]                            ready_out,
    output logic [NUM_WRITE_PORTS-1:0]                   write_en_out,
    output logic [ADDR_WIDTH*NUM_WRITE_PORTS-1:0]        write_addr_out,
    output logic [DATA_WIDTH*NUM_WRITE_PORTS-1:0]        write_data_out,
    input  logic                                         mem_ready_in,
    output logic [1:0]                                   dbg_state_o
);

    localparam int P     = NUM_WRITE_PORTS;
    localparam int AW    = ADDR_WIDTH;
    localparam int DW    = DATA_WIDTH;
    localparam int PTR_W = $clog2(NUM_EA);

    // Handshake: an expander holds en high until it sees its ready pulse;
    // memory takes the presented write on any edge with mem_ready_in high.
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, ACK = 2'd2} state_t;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    g_q, g_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [NUM_EA-1:0]   ready_q, ready_d;
    logic [P-1:0]        wen_q, wen_d;
    logic [AW*P-1:0]     waddr_q, waddr_d;
    logic [DW*P-1:0]     wdata_q, wdata_d;

    logic                found;
    logic [PTR_W-1:0]    gsel;
    logic [PTR_W-1:0]    cand;
    int                  idx;
    logic [P-1:0]        sel_mask;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] x);
        return (x == PTR_W'(NUM_EA - 1)) ? '0 : x + PTR_W'(1);
    endfunction

    // First requester at or after ptr, wrapping around.
    always_comb begin
        found = 1'b0;
        gsel  = '0;
        cand  = '0;
        idx   = 0;
        for (int i = 0; i < NUM_EA; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= NUM_EA) idx = idx - NUM_EA;
            cand = PTR_W'(idx);
            if (!found && lvv_write_en_in[cand]) begin
                found = 1'b1;
                gsel  = cand;
            end
        end
    end

    assign sel_mask = lvv_write_mask_in[int'(gsel)*P +: P];

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        ptr_d   = ptr_q;
        ready_d = '0;
        wen_d   = wen_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                wen_d = '0;
                if (found) begin
                    g_d = gsel;
                    if (sel_mask != '0) begin
                        wen_d   = sel_mask;
                        waddr_d = lvv_write_addr_in[int'(gsel)*AW*P +: AW*P];
                        wdata_d = lvv_write_data_in[int'(gsel)*DW*P +: DW*P];
                        state_d = ISSUE;
                    end else begin
                        // Nothing to write: acknowledge straight away.
                        ready_d[gsel] = 1'b1;
                        ptr_d         = next_ptr(gsel);
                        state_d       = ACK;
                    end
                end
            end
            ISSUE: begin
                if (mem_ready_in) begin
                    wen_d       = '0;
                    ready_d[g_q] = 1'b1;
                    ptr_d       = next_ptr(g_q);
                    state_d     = ACK;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            g_q     <= '0;
            ptr_q   <= '0;
            ready_q <= '0;
            wen_q   <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            ptr_q   <= ptr_d;
            ready_q <= ready_d;
            wen_q   <= wen_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign ready_out      = ready_q;
    assign write_en_out   = wen_q;
    assign write_addr_out = waddr_q;
    assign write_data_out = wdata_q;
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_gerenciador_escritas.sv
// Directed plus randomized bench for gerenciador_escritas against a
// transaction-level round-robin reference model.
module tb_gerenciador_escritas;

    localparam int P  = 8;
    localparam int NE = 8;
    localparam int DW = 32;
    localparam int AW = 8;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic [NE-1:0]        en_in;
    logic [AW*P*NE-1:0]   addr_in;
    logic [DW*P*NE-1:0]   data_in;
    logic [P*NE-1:0]      mask_in;
    logic                 mem_ready = 1'b0;
    logic [NE-1:0]        ready_out;
    logic [P-1:0]         write_en_out;
    logic [AW*P-1:0]      write_addr_out;
    logic [DW*P-1:0]      write_data_out;
    logic [1:0]           dbg_state;

    // Bench-side view of each expander's request.
    logic [NE-1:0]        en_m;
    logic [AW-1:0]        a_m [NE][P];
    logic [DW-1:0]        d_m [NE][P];
    logic [P-1:0]         m_m [NE];

    int ptr_m;
    logic [AW*P-1:0] last_a;
    logic [DW*P-1:0] last_d;
    int checks   = 0;
    int failures = 0;

    gerenciador_escritas #(
        .NUM_WRITE_PORTS(P), .NUM_EA(NE), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .lvv_write_en_in(en_in),
        .lvv_write_addr_in(addr_in),
        .lvv_write_data_in(data_in),
        .lvv_write_mask_in(mask_in),
        .ready_out(ready_out),
        .write_en_out(write_en_out),
        .write_addr_out(write_addr_out),
        .write_data_out(write_data_out),
        .mem_ready_in(mem_ready),
        .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    always_comb begin
        en_in   = en_m;
        addr_in = '0;
        data_in = '0;
        mask_in = '0;
        for (int k = 0; k < NE; k++) begin
            mask_in[k*P +: P] = m_m[k];
            for (int j = 0; j < P; j++) begin
                addr_in[(k*P+j)*AW +: AW] = a_m[k][j];
                data_in[(k*P+j)*DW +: DW] = d_m[k][j];
            end
        end
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int arb(input logic [NE-1:0] en, input int ptr);
        for (int i = 0; i < NE; i++) begin
            int k;
            k = (ptr + i) % NE;
            if (en[k]) return k;
        end
        return -1;
    endfunction

    task automatic randomize_ea(input int k, input bit allow_zero);
        for (int j = 0; j < P; j++) begin
            a_m[k][j] = AW'($urandom_range(0, 255));
            d_m[k][j] = $urandom;
        end
        m_m[k] = P'($urandom_range(0, 255));
        if (allow_zero && $urandom_range(0, 3) == 0) m_m[k] = '0;
        if (!allow_zero && m_m[k] == '0) m_m[k] = 8'h01;
    endtask

    // One arbitration cycle: next edge samples IDLE, then issue/ack.
    task automatic txn(input int stall, input bit drop);
        int g;
        logic [P-1:0]    em;
        logic [AW*P-1:0] ea;
        logic [DW*P-1:0] ed;
        logic [NE-1:0]   onehot;
        g = arb(en_m, ptr_m);
        em = m_m[g];
        for (int j = 0; j < P; j++) begin
            ea[j*AW +: AW] = a_m[g][j];
            ed[j*DW +: DW] = d_m[g][j];
        end
        onehot = '0;
        onehot[g] = 1'b1;
        mem_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        if (em != '0) begin
            chk("issue_wen", write_en_out, em);
            chk("issue_addr", write_addr_out, ea);
            chk("issue_data", write_data_out, ed);
            chk("issue_ready", ready_out, '0);
            for (int s = 0; s < stall; s++) begin
                mem_ready = 1'b0;
                randomize_ea(g, 1'b1);
                @(posedge clk); #1;
                chk("hold_wen", write_en_out, em);
                chk("hold_addr", write_addr_out, ea);
                chk("hold_data", write_data_out, ed);
                chk("hold_ready", ready_out, '0);
            end
            mem_ready = 1'b1;
            @(posedge clk); #1;
            chk("done_wen", write_en_out, '0);
            chk("done_ready", ready_out, onehot);
            chk("done_addr", write_addr_out, ea);
            chk("done_data", write_data_out, ed);
            last_a = ea;
            last_d = ed;
        end else begin
            chk("zm_wen", write_en_out, '0);
            chk("zm_ready", ready_out, onehot);
            chk("zm_addr", write_addr_out, last_a);
        end
        ptr_m = (g + 1) % NE;
        if (drop) en_m[g] = 1'b0;
        mem_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        chk("ack_ready", ready_out, '0);
        chk("ack_wen", write_en_out, '0);
        chk("ack_data", write_data_out, last_d);
    endtask

    initial begin
        en_m = '0;
        for (int k = 0; k < NE; k++) begin
            m_m[k] = '0;
            for (int j = 0; j < P; j++) begin
                a_m[k][j] = '0;
                d_m[k][j] = '0;
            end
        end
        ptr_m  = 0;
        last_a = '0;
        last_d = '0;

        #1 rst = 1'b1;
        #2;
        chk("rst_ready", ready_out, '0);
        chk("rst_wen", write_en_out, '0);
        chk("rst_addr", write_addr_out, '0);
        chk("rst_data", write_data_out, '0);
        @(negedge clk); rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_wen", write_en_out, '0);
        chk("idle_ready", ready_out, '0);

        // EA3 single write on ports 0 and 2.
        m_m[3] = 8'h05;
        a_m[3][0] = 8'h10; a_m[3][2] = 8'h12;
        d_m[3][0] = 32'hA0; d_m[3][2] = 32'hA2;
        en_m[3] = 1'b1;
        txn(0, 1'b1);

        // EA7 zero mask: ptr wraps to 0, so EA0 beats EA5.
        m_m[7] = '0;
        en_m[7] = 1'b1;
        txn(0, 1'b1);
        randomize_ea(0, 1'b0);
        randomize_ea(5, 1'b0);
        en_m[0] = 1'b1; en_m[5] = 1'b1;
        txn(0, 1'b1);
        // EA5 with 4 cycles of backpressure.
        txn(4, 1'b1);

        // EA2 changes its data mid-issue.
        randomize_ea(2, 1'b0);
        d_m[2][0] = 32'h11;
        en_m[2] = 1'b1;
        txn(3, 1'b1);

        // Everyone requesting continuously: order must rotate.
        for (int k = 0; k < NE; k++) randomize_ea(k, 1'b0);
        en_m = '1;
        for (int t = 0; t < NE + 2; t++) txn(0, 1'b0);
        en_m = '0;
        txn_flush();

        // Random traffic obeying the hold-until-ready protocol.
        for (int t = 0; t < 60; t++) begin
            for (int k = 0; k < NE; k++) begin
                if (!en_m[k] && $urandom_range(0, 2) == 0) begin
                    randomize_ea(k, 1'b1);
                    en_m[k] = 1'b1;
                end
            end
            if (en_m == '0) begin
                int k;
                k = $urandom_range(0, NE - 1);
                randomize_ea(k, 1'b1);
                en_m[k] = 1'b1;
            end
            txn($urandom_range(0, 3), $urandom_range(0, 3) != 0);
        end
        en_m = '0;
        txn_flush();

        // Reset while EA1 is being issued.
        randomize_ea(5, 1'b0);
        en_m[5] = 1'b1;
        txn(0, 1'b1);
        randomize_ea(1, 1'b0);
        en_m[1] = 1'b1;
        mem_ready = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_wen", write_en_out, m_m[1]);
        randomize_ea(6, 1'b0);
        en_m[6] = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("async_rst_wen", write_en_out, '0);
        chk("async_rst_addr", write_addr_out, '0);
        chk("async_rst_data", write_data_out, '0);
        chk("async_rst_ready", ready_out, '0);
        mem_ready = 1'b1;
        @(posedge clk); #1;
        chk("in_rst_ready", ready_out, '0);
        @(negedge clk); rst = 1'b0;
        ptr_m  = 0;
        last_a = '0;
        last_d = '0;
        txn(2, 1'b1);
        txn(0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Idle a few cycles with no requests; memory strobe must stay low.
    task automatic txn_flush();
        repeat (3) begin
            @(posedge clk); #1;
            chk("flush_wen", write_en_out, '0);
            chk("flush_ready", ready_out, '0);
        end
    endtask

endmodule
